io_n_bidirectional_filtered: RTL
================================

# io_n_bidirectional_filtered

Parametrised N-channel bidirectional pad BEL for the edge IO tiles. Each channel has a configurable input path: bypass, registered, synchronised, or synchronised plus debounce-filtered. It also has an optional registered output/tristate path and registered edge-detect pulses. It instantiates inside an IO tile in place of per-pad single-channel BELs; its config bits are a slice of the tile ConfigBits vector, driven by the tile config memory.

## Interface
Parameters:
- NUM_CH, 2, number of pad channels
- SYNC_STAGES, 2, synchroniser depth (>=2)
- FILTER_W, 4, width of the shared filter-length field and per-channel counters

Ports:
- UserCLK  in  1  fabric user clock; all flops rising-edge
- UserRSTn  in  1  reset, asynchronous, active-low
- ConfigBits  in  NUM_CH*4+FILTER_W  static config; channel c uses bits [4c+3:4c], FILTER_LEN = bits [NUM_CH*4+FILTER_W-1:NUM_CH*4]
- I  in  NUM_CH  fabric-to-pad data
- T  in  NUM_CH  fabric tristate request, 1 = high-Z
- O  out  NUM_CH  pad-to-fabric data after selected input mode
- Q  out  NUM_CH  O delayed one cycle
- O_rise  out  NUM_CH  one-cycle pulse on Q 0->1
- O_fall  out  NUM_CH  one-cycle pulse on Q 1->0
- O_top  in  NUM_CH  pad input
- I_top  out  NUM_CH  pad output data
- T_top  out  NUM_CH  pad output enable, 1 = high-Z

## Operation
- Per-channel config: [1:0] IN_MODE (00 BYPASS, 01 REG, 10 SYNC, 11 FILTER), [2] OUT_REG, [3] IN_INV.
- raw = O_top ^ IN_INV. The sync chain (SYNC_STAGES flops) runs in every mode; its last stage is sync_q.
- O by mode:
  - BYPASS: O = raw, combinational.
  - REG: O = raw through one flop.
  - SYNC: O = sync_q.
  - FILTER: O = filter state.
- Filter, evaluated per edge:
  - sync_q == state: cnt <= 0.
  - sync_q != state and cnt == FILTER_LEN: state <= sync_q, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - FILTER_LEN = 0 gives a one-edge qualification.
  - Maximum FILTER_LEN is 2^FILTER_W-1. The counter never exceeds FILTER_LEN, so it never wraps.
- When IN_MODE != FILTER, state <= sync_q and cnt <= 0 each cycle. Switching into FILTER therefore causes no spurious transition.
- Q <= O every edge. O_rise = Q & ~Q_d and O_fall = ~Q & Q_d, where Q_d <= Q.
- Output path:
  - OUT_REG=0: I_top = I, T_top = T, combinational. This also holds during reset.
  - OUT_REG=1: I_top and T_top are registered from I and T.
- Config changes are legal at runtime and take effect on the next edge for registered paths, immediately for combinational paths.

## Timing
- Reset values:
  - Sync chain, REG flop, filter state, cnt, Q, Q_d: 0.
  - O_rise and O_fall: 0.
  - Registered I_top: 0. Registered T_top: 1 (pad released).
- Reset asserted mid-operation clears all state immediately. Deassertion needs no synchroniser inside the block; the tile handles it.
- Latency from an O_top change to O:
  - BYPASS: 0.
  - REG: 1 edge.
  - SYNC: SYNC_STAGES edges.
  - FILTER: SYNC_STAGES + FILTER_LEN + 1 edges.
- A glitch shorter than FILTER_LEN+1 cycles at sync_q never reaches O in FILTER mode.
- Q = O + 1 edge. O_rise/O_fall assert the edge after Q changes, for exactly 1 cycle.
- I/T to I_top/T_top latency: 0 (OUT_REG=0) or 1 edge (OUT_REG=1).
- Simultaneous sync_q return to state and cnt == FILTER_LEN: the compare uses the current sync_q, so no update occurs and cnt clears.

## Structure
- Package io_bel_pkg holds:
  - IN_MODE encodings and CFG_BITS_PER_CH = 4.
  - Config field offsets.
  - Function cfg_width(NUM_CH, FILTER_W).
- Sub-module io_in_filter: one channel's input path (inversion, sync chain, REG flop, filter, mode mux). It is generated NUM_CH times.
- The top level holds the output registers, Q/edge detect and config slicing.

## Test plan
- Reset with OUT_REG=1, T=0: T_top=1 and I_top=0 while UserRSTn=0. T_top follows T one edge after release.
- BYPASS, IN_INV=1, O_top 0->1: O drops to 0 in the same cycle. Q drops 1 edge later. O_fall pulses for 1 cycle.
- SYNC, SYNC_STAGES=2, O_top rises: O rises exactly 2 edges later. O_rise is high for one cycle at edge 4.
- FILTER, FILTER_LEN=3:
  - A 3-cycle high pulse on sync_q leaves O at 0.
  - A 4-cycle-stable high sets O at edge SYNC_STAGES+4.
- FILTER_LEN=0 vs 15 on two channels with the same stimulus: qualification takes 1 vs 16 edges. cnt never exceeds FILTER_LEN.
- Runtime mode switches SYNC->FILTER with sync_q=1 held: no O transition and no edge pulse. Async reset mid-count clears O, cnt and pulses immediately.

Source files
------------

// File: rtl/io_bel_pkg.sv
// Shared definitions for the IO tile bidirectional pad BEL.
// Contents:
//   in_mode_e        - per-channel input path selection
//   CFG_BITS_PER_CH  - config bits owned by each channel
//   CFG_* offsets    - field positions inside one channel's config nibble
//   cfg_width()      - total ConfigBits width for a given channel count
package io_bel_pkg;

    typedef enum logic [1:0] {
        IN_BYPASS = 2'b00,
        IN_REG    = 2'b01,
        IN_SYNC   = 2'b10,
        IN_FILTER = 2'b11
    } in_mode_e;

    localparam int CFG_BITS_PER_CH = 4;
    localparam int CFG_MODE_LSB    = 0;
    localparam int CFG_MODE_W      = 2;
    localparam int CFG_OUT_REG_BIT = 2;
    localparam int CFG_IN_INV_BIT  = 3;

    // Channel nibbles come first, the shared filter length sits above them.
    function automatic int cfg_width(input int num_ch, input int filter_w);
        return num_ch * CFG_BITS_PER_CH + filter_w;
    endfunction

endpackage

// File: rtl/io_in_filter.sv
// One channel's pad-to-fabric input path.
// Ports:
//   i_clk, i_rst_n  - rising-edge clock, asynchronous active-low reset
//   i_pad           - raw pad input
//   i_mode          - input mode (in_mode_e encoding)
//   i_inv           - invert the pad input before anything else
//   i_filter_len    - extra edges a new level must persist before it is accepted
//   o_data          - selected input value
module io_in_filter
    import io_bel_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_pad,
    input  logic [1:0]          i_mode,
    input  logic                i_inv,
    input  logic [FILTER_W-1:0] i_filter_len,
    output logic                o_data
);

    in_mode_e               w_mode;
    logic                   w_raw;
    logic                   w_sync_q;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_reg;
    logic                   r_state;
    logic [FILTER_W-1:0]    r_cnt;

    assign w_mode   = in_mode_e'(i_mode);
    assign w_raw    = i_pad ^ i_inv;
    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // The synchroniser and the single REG flop run in every mode so that a
    // runtime mode change always finds them holding current data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_reg  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};
            r_reg  <= w_raw;
        end
    end

    // Outside FILTER mode the filter tracks sync_q, so entering FILTER never
    // produces a spurious transition. cnt is capped at i_filter_len by the
    // acceptance branch and therefore cannot wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= 1'b0;
            r_cnt   <= '0;
        end else if (w_mode != IN_FILTER) begin
            r_state <= w_sync_q;
            r_cnt   <= '0;
        end else if (w_sync_q == r_state) begin
            r_cnt   <= '0;
        end else if (r_cnt == i_filter_len) begin
            r_state <= w_sync_q;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        o_data = w_raw;
        case (w_mode)
            IN_BYPASS: o_data = w_raw;
            IN_REG:    o_data = r_reg;
            IN_SYNC:   o_data = w_sync_q;
            IN_FILTER: o_data = r_state;
            default:   o_data = w_raw;
        endcase
    end

endmodule

// File: rtl/io_n_bidirectional_filtered.sv
// N-channel bidirectional pad BEL for the edge IO tiles.
// Ports:
//   UserCLK, UserRSTn - fabric clock, asynchronous active-low reset
//   ConfigBits        - per-channel nibble {IN_INV, OUT_REG, IN_MODE[1:0]},
//                       shared FILTER_LEN above the channel nibbles
//   I, T              - fabric data / tristate request towards the pad
//   O, Q              - input value after mode selection, and O one edge later
//   O_rise, O_fall    - one-cycle pulses following a Q transition
//   O_top             - pad input
//   I_top, T_top      - pad output data / output enable (1 = high-Z)
module io_n_bidirectional_filtered
    import io_bel_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4
) (
    input  logic                                   UserCLK,
    input  logic                                   UserRSTn,
    input  logic [cfg_width(NUM_CH, FILTER_W)-1:0] ConfigBits,
    input  logic [NUM_CH-1:0]                      I,
    input  logic [NUM_CH-1:0]                      T,
    output logic [NUM_CH-1:0]                      O,
    output logic [NUM_CH-1:0]                      Q,
    output logic [NUM_CH-1:0]                      O_rise,
    output logic [NUM_CH-1:0]                      O_fall,
    input  logic [NUM_CH-1:0]                      O_top,
    output logic [NUM_CH-1:0]                      I_top,
    output logic [NUM_CH-1:0]                      T_top
);

    logic [FILTER_W-1:0] w_filter_len;
    logic [NUM_CH-1:0]   w_out_reg;
    logic [NUM_CH-1:0]   r_q;
    logic [NUM_CH-1:0]   r_qd;
    logic [NUM_CH-1:0]   r_rise;
    logic [NUM_CH-1:0]   r_fall;
    logic [NUM_CH-1:0]   r_itop;
    logic [NUM_CH-1:0]   r_ttop;

    assign w_filter_len = ConfigBits[NUM_CH*CFG_BITS_PER_CH +: FILTER_W];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CFG_BITS_PER_CH-1:0] w_cfg;

        assign w_cfg        = ConfigBits[c*CFG_BITS_PER_CH +: CFG_BITS_PER_CH];
        assign w_out_reg[c] = w_cfg[CFG_OUT_REG_BIT];

        io_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_W    (FILTER_W)
        ) u_in (
            .i_clk        (UserCLK),
            .i_rst_n      (UserRSTn),
            .i_pad        (O_top[c]),
            .i_mode       (w_cfg[CFG_MODE_LSB +: CFG_MODE_W]),
            .i_inv        (w_cfg[CFG_IN_INV_BIT]),
            .i_filter_len (w_filter_len),
            .o_data       (O[c])
        );

        // Unregistered channels pass I/T straight through, even in reset.
        assign I_top[c] = w_out_reg[c] ? r_itop[c] : I[c];
        assign T_top[c] = w_out_reg[c] ? r_ttop[c] : T[c];
    end

    // Edge pulses are registered from Q/Q_d, so they appear one edge after Q
    // changes. The output registers sample every edge; T resets to released.
    always_ff @(posedge UserCLK or negedge UserRSTn) begin
        if (!UserRSTn) begin
            r_q    <= '0;
            r_qd   <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_itop <= '0;
            r_ttop <= '1;
        end else begin
            r_q    <= O;
            r_qd   <= r_q;
            r_rise <= r_q & ~r_qd;
            r_fall <= ~r_q & r_qd;
            r_itop <= I;
            r_ttop <= T;
        end
    end

    assign Q      = r_q;
    assign O_rise = r_rise;
    assign O_fall = r_fall;

endmodule
